// File: rtl/varclk_sequencer_if.sv
// Segment stream between the host-loaded segment FIFO and the sequencer.
interface varclk_sequencer_if #(
  parameter int unsigned CNT_W = 48,
  parameter int unsigned REP_W = 32,
  parameter int unsigned NCH   = 4
) ();
  logic [CNT_W-1:0] seg_on;
  logic [CNT_W-1:0] seg_off;
  logic [REP_W-1:0] seg_rep;
  logic [NCH-1:0]   seg_mask;
  logic             seg_valid;
  logic             seg_ready;

  modport master (
    output seg_on, seg_off, seg_rep, seg_mask, seg_valid,
    input  seg_ready
  );

  modport slave (
    input  seg_on, seg_off, seg_rep, seg_mask, seg_valid,
    output seg_ready
  );
endinterface

// File: rtl/varclk_sequencer.sv
// Multi-channel gated sample-clock sequencer fed by a stream of clock segments.
module varclk_sequencer #(
  parameter int unsigned CNT_W  = 48,
  parameter int unsigned REP_W  = 32,
  parameter int unsigned NCH    = 4,
  parameter int unsigned STAT_W = 32
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  varclk_sequencer_if.slave seg,
  input  logic              retrig_in,
  input  logic              toggle_in,
  output logic [NCH-1:0]    clk_out,
  output logic              toggle_out,
  output logic              busy,
  output logic              done,
  output logic [STAT_W-1:0] tick_count,
  output logic [STAT_W-1:0] edge_count,
  output logic [STAT_W-1:0] mistrig_idx,
  output logic [15:0]       timeout_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        r_state,   w_state_n;
  logic [CNT_W-1:0]  r_phase,   w_phase_n;
  logic [REP_W-1:0]  r_rep_cnt, w_rep_cnt_n;
  logic [CNT_W-1:0]  r_wait_cnt, w_wait_cnt_n;
  logic [CNT_W-1:0]  r_on,  w_on_n;
  logic [CNT_W-1:0]  r_off, w_off_n;
  logic [REP_W-1:0]  r_rep, w_rep_n;
  logic [NCH-1:0]    r_mask, w_mask_n;
  logic [NCH-1:0]    r_clk_out, w_clk_out_n;
  logic              r_toggle, w_toggle_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;
  logic [STAT_W-1:0] r_tick, w_tick_n;
  logic [STAT_W-1:0] r_edge, w_edge_n;
  logic [STAT_W-1:0] r_mistrig, w_mistrig_n;
  logic [15:0]       r_tmo, w_tmo_n;

  logic [CNT_W-1:0]  w_last_phase;
  logic              w_period_end, w_gen_end, w_timeout, w_wait_exit;
  logic              w_ready, w_take, w_first, w_load, w_rise;
  logic [STAT_W-1:0] w_edge_base, w_mistrig_base;

  // Period boundaries and segment-end / wait-exit detection.
  always_comb begin
    w_last_phase = r_on + ((r_off == '0) ? '0 : (r_off - CNT_W'(1)));
    w_period_end = (r_phase == w_last_phase);
    w_gen_end    = (r_state == S_GEN) && w_period_end &&
                   (r_rep_cnt == (r_rep - REP_W'(1)));
    w_timeout    = (r_on != '0) && (r_wait_cnt == r_on);
    w_wait_exit  = (r_state == S_WAIT) && (retrig_in || w_timeout);
  end

  // Segment handshake: accept on start in IDLE or at the end of the current segment.
  always_comb begin
    w_ready = 1'b0;
    if (r_state == S_IDLE) begin
      w_ready = start & seg.seg_valid & ~abort;
    end else if (w_gen_end || w_wait_exit) begin
      w_ready = seg.seg_valid & ~abort;
    end
  end

  assign seg.seg_ready  = w_ready;
  assign w_take         = w_ready & seg.seg_valid;
  assign w_first        = (r_state == S_IDLE) && w_take;
  assign w_edge_base    = w_first ? '0 : r_edge;
  assign w_mistrig_base = w_first ? '0 : r_mistrig;

  // Next-state and registered-output computation.
  always_comb begin
    w_state_n    = r_state;
    w_phase_n    = r_phase;
    w_rep_cnt_n  = r_rep_cnt;
    w_wait_cnt_n = r_wait_cnt;
    w_on_n       = r_on;
    w_off_n      = r_off;
    w_rep_n      = r_rep;
    w_mask_n     = r_mask;
    w_toggle_n   = r_toggle;
    w_done_n     = 1'b0;
    w_tick_n     = w_first ? '0 : r_tick;
    w_edge_n     = w_edge_base;
    w_mistrig_n  = w_mistrig_base;
    w_tmo_n      = w_first ? '0 : r_tmo;
    w_load       = 1'b0;
    w_rise       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_take) w_load = 1'b1;
      end
      S_GEN: begin
        w_tick_n = r_tick + STAT_W'(1);
        if (abort) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end else if (w_gen_end) begin
          if (w_take) begin
            w_load = 1'b1;
          end else begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end
        end else if (w_period_end) begin
          w_phase_n   = '0;
          w_rep_cnt_n = r_rep_cnt + REP_W'(1);
        end else begin
          w_phase_n = r_phase + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end else if (w_wait_exit) begin
          if (w_timeout && !retrig_in && (r_tmo != 16'hFFFF)) begin
            w_tmo_n = r_tmo + 16'd1;
          end
          if (w_take) begin
            w_load = 1'b1;
          end else begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
          end
        end else begin
          w_wait_cnt_n = r_wait_cnt + CNT_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_load) begin
      w_state_n    = (seg.seg_rep != '0) ? S_GEN : S_WAIT;
      w_phase_n    = '0;
      w_rep_cnt_n  = '0;
      w_wait_cnt_n = '0;
      w_on_n       = seg.seg_on;
      w_off_n      = seg.seg_off;
      w_rep_n      = seg.seg_rep;
      w_mask_n     = seg.seg_mask;
    end

    // Phase 0 of a period with a non-zero high time is a generated rising edge.
    w_rise = (w_state_n == S_GEN) && (w_phase_n == '0) && (w_on_n != '0);
    if (w_rise) begin
      w_edge_n   = w_edge_base + STAT_W'(1);
      w_toggle_n = ~r_toggle;
      if ((r_toggle != toggle_in) && (w_mistrig_base == '0)) begin
        w_mistrig_n = w_edge_base + STAT_W'(1);
      end
    end

    w_clk_out_n = ((w_state_n == S_GEN) && (w_phase_n < w_on_n)) ? w_mask_n : '0;
    w_busy_n    = (w_state_n != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_rep_cnt  <= '0;
      r_wait_cnt <= '0;
      r_on       <= '0;
      r_off      <= '0;
      r_rep      <= '0;
      r_mask     <= '0;
      r_clk_out  <= '0;
      r_toggle   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tick     <= '0;
      r_edge     <= '0;
      r_mistrig  <= '0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_phase    <= w_phase_n;
      r_rep_cnt  <= w_rep_cnt_n;
      r_wait_cnt <= w_wait_cnt_n;
      r_on       <= w_on_n;
      r_off      <= w_off_n;
      r_rep      <= w_rep_n;
      r_mask     <= w_mask_n;
      r_clk_out  <= w_clk_out_n;
      r_toggle   <= w_toggle_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_tick     <= w_tick_n;
      r_edge     <= w_edge_n;
      r_mistrig  <= w_mistrig_n;
      r_tmo      <= w_tmo_n;
    end
  end

  assign clk_out       = r_clk_out;
  assign toggle_out    = r_toggle;
  assign busy          = r_busy;
  assign done          = r_done;
  assign tick_count    = r_tick;
  assign edge_count    = r_edge;
  assign mistrig_idx   = r_mistrig;
  assign timeout_count = r_tmo;

endmodule
